// File: rtl/alan_sayaci.sv
// alan_sayaci: up/down counter for one date/time field (day, month, year,
// hour, minute). It wraps between MIN_DEGER and a runtime upper limit.
// Carry and borrow pulses in and out let several stages be chained.
// The increment and decrement buttons are edge-detected by a small FSM.
// Optional feature macro: OTOMATIK_TEKRAR_EN. When it is defined, holding
// one button auto-repeats: the first repeat comes after RPT_GECIKME cycles,
// and then one repeat follows every RPT_PERIYOT cycles.
module alan_sayaci #(
    parameter int unsigned WIDTH       = 6,
    parameter int unsigned MIN_DEGER   = 1,
    parameter int unsigned MAX_DEGER   = 12,
    parameter int unsigned RPT_GECIKME = 50000000,
    parameter int unsigned RPT_PERIYOT = 10000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stop,
    input  logic             artir_btn,
    input  logic             azalt_btn,
    input  logic             artir_in,
    input  logic             azalt_in,
    input  logic [WIDTH-1:0] ust_sinir,
    output logic             artir_out,
    output logic             azalt_out,
    output logic [WIDTH-1:0] deger
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_DEGER);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_DEGER);
    localparam logic [WIDTH-1:0] BIR_W = WIDTH'(1);

    typedef enum logic [0:0] {
        BEKLE  = 1'b0,
        BASILI = 1'b1
    } durum_t;

    durum_t           durum_r;
    durum_t           durum_s;
    logic             tek_s;
    logic             btn_artir_olay_s;
    logic             btn_azalt_olay_s;
    logic             rpt_olay_s;
    logic             inc_s;
    logic             dec_s;
    logic [WIDTH-1:0] ust_s;
    logic [WIDTH-1:0] deger_r;
    logic             artir_out_r;
    logic             azalt_out_r;

    // This is high when exactly one button is held. Only then can a button event occur.
    assign tek_s = artir_btn ^ azalt_btn;

    // Clamp the runtime limit into [MIN_DEGER, MAX_DEGER].
    always_comb begin
        ust_s = ust_sinir;
        if (ust_sinir < MIN_W) begin
            ust_s = MIN_W;
        end else if (ust_sinir > MAX_W) begin
            ust_s = MAX_W;
        end else begin
            ust_s = ust_sinir;
        end
    end

`ifdef OTOMATIK_TEKRAR_EN
    logic [31:0] rpt_say_r;
    logic        rpt_faz_r;
    logic [31:0] rpt_hedef_s;

    // The first target is the initial delay. After the first repeat, the target is the period.
    assign rpt_hedef_s = rpt_faz_r ? (RPT_PERIYOT - 32'd1) : (RPT_GECIKME - 32'd1);
    assign rpt_olay_s  = (durum_r == BASILI) && tek_s && (rpt_say_r == rpt_hedef_s);

    // Hold counter. It runs only in BASILI with a single button held, and restarts on every repeat event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_say_r <= 32'd0;
            rpt_faz_r <= 1'b0;
        end else if ((durum_r != BASILI) || !tek_s) begin
            rpt_say_r <= 32'd0;
            rpt_faz_r <= 1'b0;
        end else if (rpt_say_r == rpt_hedef_s) begin
            rpt_say_r <= 32'd0;
            rpt_faz_r <= 1'b1;
        end else begin
            rpt_say_r <= rpt_say_r + 32'd1;
            rpt_faz_r <= rpt_faz_r;
        end
    end
`else
    assign rpt_olay_s = 1'b0;

    // Repeat timing has no effect in this build. An empty guard block keeps the parameters referenced.
    if ((RPT_GECIKME == 0) || (RPT_PERIYOT == 0)) begin : g_rpt_etkisiz
    end
`endif

    // Button FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            durum_r <= BEKLE;
        end else begin
            durum_r <= durum_s;
        end
    end

    // Next state and events. An event occurs on a press from idle, or on a repeat while held.
    always_comb begin
        durum_s          = durum_r;
        btn_artir_olay_s = 1'b0;
        btn_azalt_olay_s = 1'b0;
        case (durum_r)
            BEKLE: begin
                if (artir_btn || azalt_btn) begin
                    durum_s          = BASILI;
                    btn_artir_olay_s = tek_s && artir_btn;
                    btn_azalt_olay_s = tek_s && azalt_btn;
                end else begin
                    durum_s = BEKLE;
                end
            end
            BASILI: begin
                if (!artir_btn && !azalt_btn) begin
                    durum_s = BEKLE;
                end else begin
                    durum_s          = BASILI;
                    btn_artir_olay_s = rpt_olay_s && artir_btn;
                    btn_azalt_olay_s = rpt_olay_s && azalt_btn;
                end
            end
            default: begin
                durum_s = BEKLE;
            end
        endcase
    end

    assign inc_s = artir_in || btn_artir_olay_s;
    assign dec_s = azalt_in || btn_azalt_olay_s;

    // Field value and wrap pulses. stop freezes everything, and any event is dropped.
    // A limit that has shrunk is fixed before any request is served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deger_r     <= MIN_W;
            artir_out_r <= 1'b0;
            azalt_out_r <= 1'b0;
        end else if (stop) begin
            deger_r     <= deger_r;
            artir_out_r <= 1'b0;
            azalt_out_r <= 1'b0;
        end else if (deger_r > ust_s) begin
            deger_r     <= ust_s;
            artir_out_r <= 1'b0;
            azalt_out_r <= 1'b0;
        end else if (inc_s && !dec_s) begin
            if (deger_r == ust_s) begin
                deger_r     <= MIN_W;
                artir_out_r <= 1'b1;
            end else begin
                deger_r     <= deger_r + BIR_W;
                artir_out_r <= 1'b0;
            end
            azalt_out_r <= 1'b0;
        end else if (dec_s && !inc_s) begin
            if (deger_r == MIN_W) begin
                deger_r     <= ust_s;
                azalt_out_r <= 1'b1;
            end else begin
                deger_r     <= deger_r - BIR_W;
                azalt_out_r <= 1'b0;
            end
            artir_out_r <= 1'b0;
        end else begin
            deger_r     <= deger_r;
            artir_out_r <= 1'b0;
            azalt_out_r <= 1'b0;
        end
    end

    assign deger     = deger_r;
    assign artir_out = artir_out_r;
    assign azalt_out = azalt_out_r;

endmodule

// File: doc/alan_sayaci.md
Name: alan_sayaci

Overview:
- Parametrised up/down field counter for one date/time field (day, month, year, hour, minute).
- Generalises the fixed 1..12 month counter: configurable width and limits, runtime upper limit (days-in-month), chainable carry/borrow in and out, edge-detected buttons.
- Instances chain lower-to-higher field: artir_out of one stage drives artir_in of the next.

Parameters:
- WIDTH, 6, width of deger and ust_sinir.
- MIN_DEGER, 1, lowest field value and reset value.
- MAX_DEGER, 12, absolute upper limit; effective limit never exceeds it.
- RPT_GECIKME, 50000000, hold cycles before auto-repeat starts (OTOMATIK_TEKRAR_EN only).
- RPT_PERIYOT, 10000000, cycles between repeat events (OTOMATIK_TEKRAR_EN only).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- stop  input  1  freeze: value and outputs held while 1.
- artir_btn  input  1  increment button, level, already synchronised.
- azalt_btn  input  1  decrement button, level, already synchronised.
- artir_in  input  1  single-cycle carry from lower stage.
- azalt_in  input  1  single-cycle borrow from lower stage.
- ust_sinir  input  WIDTH  runtime upper limit (e.g. 28/29/30/31); tie to MAX_DEGER if unused.
- artir_out  output  1  registered single-cycle carry pulse to next stage.
- azalt_out  output  1  registered single-cycle borrow pulse to next stage.
- deger  output  WIDTH  current field value, registered.

Behaviour:
- Reset (reset=0, async): deger=MIN_DEGER, artir_out=0, azalt_out=0, button FSM=BEKLE, repeat counter=0.
- Effective limit ust = ust_sinir clamped into [MIN_DEGER, MAX_DEGER].
- Button FSM, two states:
  - BEKLE: exactly one button high -> go to BASILI and emit one button event (inc or dec).
  - BASILI: stays until both buttons low, then returns to BEKLE. No further events without OTOMATIK_TEKRAR_EN.
  - Both buttons high in BEKLE: go to BASILI with no event.
- FSM runs regardless of stop. An event generated while stop=1 is discarded, so releasing stop never produces a stale event.
- Requests: inc = artir_in OR button-inc event; dec = azalt_in OR button-dec event.
- inc and dec in the same cycle: net zero, no value change, no pulses.
- Update rules, applied one cycle after the request, in priority order:
  - stop=1: hold deger; artir_out=azalt_out=0.
  - deger > ust (limit shrank): deger <= ust, no pulse. Any request that cycle is dropped.
  - inc and deger == ust: deger <= MIN_DEGER, artir_out=1 for exactly one cycle.
  - inc otherwise: deger+1.
  - dec and deger == MIN_DEGER: deger <= ust, azalt_out=1 for exactly one cycle.
  - dec otherwise: deger-1.
- Pulses are never sticky; artir_out/azalt_out are 0 in every cycle without a wrap.
- Arithmetic is WIDTH bits, unsigned; MAX_DEGER < 2^WIDTH is guaranteed by the instantiator.
- Latency: input pulse or button rising edge -> deger and pulse change on the next rising clk.
- Reset mid-hold: FSM returns to BEKLE. If a button is still held after reset release, one event is generated.

Optional Feature:
- OTOMATIK_TEKRAR_EN defined: in BASILI with exactly one button held, a counter runs.
  - After RPT_GECIKME cycles, one event of the held direction; then one event every RPT_PERIYOT cycles.
  - Counter clears on release, on both buttons high, or on reset.
  - Events obey stop and the update rules above.
- Not defined: counter logic absent; exactly one event per press.

Test Plan:
- Reset then release; pulse artir_in 11 times (MIN=1, MAX=12, ust_sinir=12) -> deger 1..12. 12th pulse -> deger=1, artir_out high exactly one cycle.
- deger=1, press azalt_btn for 20 cycles -> deger=12 one cycle later, single azalt_out pulse, no further change during hold.
- MAX=31, deger=31, change ust_sinir to 30 -> next cycle deger=30, no pulse. ust_sinir=40 -> effective limit 31.
- artir_in and azalt_btn rising edge in same cycle at deger=5 -> deger stays 5, no pulses. Both buttons pressed together -> no change.
- stop=1, press/release artir_btn and pulse artir_in -> deger frozen; stop=0 -> no delayed increment.
- OTOMATIK_TEKRAR_EN, RPT_GECIKME=10, RPT_PERIYOT=4, hold artir_btn 30 cycles from deger=1 -> increments at cycles 1, 11, 15, 19, 23, 27 -> deger=7.
